enemy_health_bars: RTL

ENEMY_HEALTH_BARS -- requirements
Module: enemy_health_bars

---
 rtl/enemy_health_bars_if.sv | 45 ++++
 rtl/enemy_health_bars.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_health_bars_if.sv
// -----------------------------------------------------------------------------
// enemy_health_bars_if
//
// Groups the pixel-pipeline and game-event signals of enemy_health_bars.
// clk and resetN stay outside the interface as plain ports.
//
// Signals (N = NUM_ENEMIES):
//   startOfFrame   game -> bars   one-cycle pulse at frame start
//   pixelX/pixelY  game -> bars   current VGA pixel, 11 bits each
//   topLeftXinput  game -> bars   11*N packed X positions, channel i at [11i+10:11i]
//   topLeftYinput  game -> bars   11*N packed Y positions, same packing
//   hitPulse       game -> bars   N one-cycle damage requests
//   respawn        game -> bars   N one-cycle health reload requests
//   RGBout         bars -> game   8-bit bar pixel color (8'hFF = transparent)
//   drawingRequest bars -> game   current pixel belongs to some bar
//   deadMask       bars -> game   bit i high while health[i] == 0
//
// Modports: master = game/video side, slave = enemy_health_bars.
// -----------------------------------------------------------------------------
interface enemy_health_bars_if #(
    parameter int NUM_ENEMIES = 4
);
    logic                       startOfFrame;
    logic [10:0]                pixelX;
    logic [10:0]                pixelY;
    logic [11*NUM_ENEMIES-1:0]  topLeftXinput;
    logic [11*NUM_ENEMIES-1:0]  topLeftYinput;
    logic [NUM_ENEMIES-1:0]     hitPulse;
    logic [NUM_ENEMIES-1:0]     respawn;
    logic [7:0]                 RGBout;
    logic                       drawingRequest;
    logic [NUM_ENEMIES-1:0]     deadMask;

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftXinput, topLeftYinput,
        output hitPulse, respawn,
        input  RGBout, drawingRequest, deadMask
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftXinput, topLeftYinput,
        input  hitPulse, respawn,
        output RGBout, drawingRequest, deadMask
    );
endinterface

// File: rtl/enemy_health_bars.sv
// -----------------------------------------------------------------------------
// enemy_health_bars
//
// Tracks the health of NUM_ENEMIES enemies and draws a horizontal health bar
// above each one. The filled fraction of a bar is health/MAX_HEALTH; a dead
// enemy (health 0) draws nothing. Where bars overlap, the lowest channel wins.
//
// Ports:
//   clk     system clock
//   resetN  asynchronous active-low reset (full health, no flash, outputs idle)
//   bus     enemy_health_bars_if.slave -- pixel position, enemy positions,
//           hit/respawn pulses, startOfFrame in; RGBout, drawingRequest,
//           deadMask out
//
// Timing: RGBout/drawingRequest are registered, one cycle after pixelX/pixelY,
// using the health held in the registers during the pixel's cycle.
// deadMask is combinational from the health registers.
//
// Optional feature: define HEALTH_FLASH_EN to make a bar blink in FLASH_COLOR
// for FLASH_FRAMES frames after each hit. Without it, no flash counters exist,
// startOfFrame is ignored and colors follow the fill level only.
// -----------------------------------------------------------------------------
module enemy_health_bars #(
    parameter int         NUM_ENEMIES    = 4,
    parameter int         OBJECT_WIDTH_X = 20,
    parameter int         BAR_OFFSET_Y   = 10,
    parameter int         BAR_HEIGHT     = 4,
    parameter int         MAX_HEALTH     = 8,
    parameter int         DAMAGE         = 2,
    parameter logic [7:0] FULL_COLOR     = 8'h1C,
    parameter logic [7:0] EMPTY_COLOR    = 8'hE0,
    parameter logic [7:0] FLASH_COLOR    = 8'hFF,
    parameter int         FLASH_FRAMES   = 6
) (
    input  logic               clk,
    input  logic               resetN,
    enemy_health_bars_if.slave bus
);

    localparam int HW = $clog2(MAX_HEALTH + 1);   // health register width
    localparam int CW = 13;                       // signed geometry width

    localparam logic [7:0] TRANSPARENT = 8'hFF;

    localparam logic signed [CW-1:0] BAR_W   = CW'(OBJECT_WIDTH_X);
    localparam logic signed [CW-1:0] BAR_H   = CW'(BAR_HEIGHT);
    localparam logic signed [CW-1:0] BAR_OFF = CW'(BAR_OFFSET_Y);

    localparam logic [HW-1:0] HEALTH_FULL = HW'(MAX_HEALTH);

    // -------------------------------------------------------------------------
    // Health registers
    // -------------------------------------------------------------------------
    logic [HW-1:0] health [NUM_ENEMIES];

    // Saturating subtract: compared in full int width so a DAMAGE larger than
    // the register range still floors at zero instead of wrapping.
    function automatic logic [HW-1:0] take_damage(input logic [HW-1:0] h);
        if (int'(h) <= DAMAGE)
            return '0;
        else
            return h - HW'(DAMAGE);
    endfunction

    // NOTE: every register here uses non-blocking assignment so all channels
    // update from the same pre-edge values, independent of statement order.
    // NOTE: the health bank is a small register array, not a memory, so each
    // entry is reset explicitly -- enemies must start at full health.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_ENEMIES; i++)
                health[i] <= HEALTH_FULL;
        end else begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (bus.respawn[i])
                    health[i] <= HEALTH_FULL;       // respawn beats a same-cycle hit
                else if (bus.hitPulse[i])
                    health[i] <= take_damage(health[i]);
            end
        end
    end

    logic [NUM_ENEMIES-1:0] dead;

    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++)
            dead[i] = (health[i] == '0);
    end

    assign bus.deadMask = dead;

    // -------------------------------------------------------------------------
    // Flash counters (optional)
    // -------------------------------------------------------------------------
    logic [NUM_ENEMIES-1:0] flashing;

`ifdef HEALTH_FLASH_EN
    localparam int FW = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

    logic [FW-1:0] flash_cnt [NUM_ENEMIES];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_ENEMIES; i++)
                flash_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (bus.respawn[i])
                    flash_cnt[i] <= '0;
                else if (bus.hitPulse[i])
                    flash_cnt[i] <= FW'(FLASH_FRAMES);   // load beats the frame decrement
                else if (bus.startOfFrame && flash_cnt[i] != '0)
                    flash_cnt[i] <= flash_cnt[i] - 1'b1;
            end
        end
    end

    // An odd count is necessarily nonzero, so bit 0 alone selects flash frames.
    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++)
            flashing[i] = flash_cnt[i][0];
    end
`else
    assign flashing = '0;
`endif

    // -------------------------------------------------------------------------
    // Per-channel bar hit test and fill test
    // -------------------------------------------------------------------------
    logic signed [CW-1:0] px;
    logic signed [CW-1:0] py;

    // Pixel coordinates are non-negative, so a bar whose top lies above row 0
    // clips naturally against the signed compare; nothing wraps to row 2047.
    assign px = $signed({{(CW-11){1'b0}}, bus.pixelX});
    assign py = $signed({{(CW-11){1'b0}}, bus.pixelY});

    logic [NUM_ENEMIES-1:0] in_bar;
    logic [NUM_ENEMIES-1:0] filled;

    always_comb begin
        logic signed [CW-1:0] left;
        logic signed [CW-1:0] top;
        logic signed [CW-1:0] dx;
        logic [31:0]          fill_lhs;
        logic [31:0]          fill_rhs;

        // NOTE: defaults first so no path through the loop infers a latch.
        in_bar   = '0;
        filled   = '0;
        left     = '0;
        top      = '0;
        dx       = '0;
        fill_lhs = '0;
        fill_rhs = '0;

        for (int i = 0; i < NUM_ENEMIES; i++) begin
            left = $signed({{(CW-11){1'b0}}, bus.topLeftXinput[11*i +: 11]});
            top  = $signed({{(CW-11){1'b0}}, bus.topLeftYinput[11*i +: 11]}) - BAR_OFF;

            in_bar[i] = (px >= left) && (px < left + BAR_W) &&
                        (py >= top)  && (py < top + BAR_H)  &&
                        (health[i] != '0);

            // Fill boundary without a divider:
            //   (x - left) / width < health / max  <=>  (x - left)*max < health*width
            // dx is only meaningful (non-negative) when the pixel is in the bar.
            dx        = px - left;
            fill_lhs  = 32'($unsigned(dx)) * 32'(MAX_HEALTH);
            fill_rhs  = 32'(health[i]) * 32'(OBJECT_WIDTH_X);
            filled[i] = (fill_lhs < fill_rhs);
        end
    end

    // -------------------------------------------------------------------------
    // Owner selection and registered pixel output
    // -------------------------------------------------------------------------
    logic       draw_next;
    logic [7:0] rgb_next;

    // Scanning from the highest index down lets the lowest overlapping
    // channel overwrite the others and own the pixel.
    always_comb begin
        draw_next = 1'b0;
        rgb_next  = TRANSPARENT;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (in_bar[i]) begin
                draw_next = 1'b1;
                if (flashing[i])
                    rgb_next = FLASH_COLOR;
                else if (filled[i])
                    rgb_next = FULL_COLOR;
                else
                    rgb_next = EMPTY_COLOR;
            end
        end
    end

    logic       draw_q;
    logic [7:0] rgb_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            draw_q <= 1'b0;
            rgb_q  <= TRANSPARENT;
        end else begin
            draw_q <= draw_next;
            rgb_q  <= rgb_next;
        end
    end

    assign bus.drawingRequest = draw_q;
    assign bus.RGBout         = rgb_q;

endmodule
